pulse_measure: RTL

PULSE_MEASURE -- requirements
Module: pulse_measure

---
 rtl/pulse_measure.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_measure.sv
// Pulse delay/width measurement: times trigger-to-pulse delay and pulse
// high time in clk cycles, with a per-phase timeout.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   trigger_in, pulse_in  asynchronous inputs (synchronized internally)
//   running               measurement in progress
//   result_valid          one-cycle strobe when a new result is presented
//   timeout               result ended by timeout
//   delay_out, width_out  measured delay and pulse width in clk cycles
module pulse_measure #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] TIMEOUT     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger_in,
    input  logic        pulse_in,
    output logic        running,
    output logic        result_valid,
    output logic        timeout,
    output logic [31:0] delay_out,
    output logic [31:0] width_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PULSE,
        MEASURE
    } state_t;

    // Edges are suppressed until the synchronizers and edge flops hold
    // real samples, so a level already high at reset release is not
    // mistaken for a rise.
    localparam int unsigned SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] trig_sync_q;
    logic [SYNC_STAGES-1:0] pulse_sync_q;
    logic                   trig_d1_q;
    logic                   pulse_d1_q;
    logic [SW-1:0]          settle_q;

    logic trig_s;
    logic pulse_s;
    logic settled;
    logic trig_rise;
    logic pulse_rise;
    logic pulse_fall;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] dly_lat_q, dly_lat_d;
    logic        running_q, running_d;
    logic        rv_q, rv_d;
    logic        to_q, to_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] width_q, width_d;

    assign trig_s  = trig_sync_q[SYNC_STAGES-1];
    assign pulse_s = pulse_sync_q[SYNC_STAGES-1];
    assign settled = (settle_q == SETTLE);

    assign trig_rise  = settled & trig_s & ~trig_d1_q;
    assign pulse_rise = settled & pulse_s & ~pulse_d1_q;
    assign pulse_fall = settled & ~pulse_s & pulse_d1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_sync_q  <= '0;
            pulse_sync_q <= '0;
            trig_d1_q    <= 1'b0;
            pulse_d1_q   <= 1'b0;
            settle_q     <= '0;
        end else begin
            trig_sync_q  <= {trig_sync_q[SYNC_STAGES-2:0], trigger_in};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], pulse_in};
            trig_d1_q    <= trig_s;
            pulse_d1_q   <= pulse_s;
            if (!settled) begin
                settle_q <= settle_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dly_lat_q <= '0;
            running_q <= 1'b0;
            rv_q      <= 1'b0;
            to_q      <= 1'b0;
            delay_q   <= '0;
            width_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_lat_q <= dly_lat_d;
            running_q <= running_d;
            rv_q      <= rv_d;
            to_q      <= to_d;
            delay_q   <= delay_d;
            width_q   <= width_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dly_lat_d = dly_lat_q;
        running_d = running_q;
        rv_d      = 1'b0;
        to_d      = to_q;
        delay_d   = delay_q;
        width_d   = width_q;

        unique case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    running_d = 1'b1;
                    cnt_d     = 32'd1;
                    if (pulse_rise) begin
                        dly_lat_d = '0;
                        state_d   = MEASURE;
                    end else begin
                        state_d   = WAIT_PULSE;
                    end
                end
            end

            WAIT_PULSE: begin
                if (pulse_rise) begin
                    dly_lat_d = cnt_q;
                    cnt_d     = 32'd1;
                    state_d   = MEASURE;
                end else if (cnt_q == TIMEOUT) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    running_d = 1'b0;
                    rv_d      = 1'b1;
                    to_d      = 1'b1;
                    delay_d   = TIMEOUT;
                    width_d   = TIMEOUT;
                end else begin
                    cnt_d     = cnt_q + 32'd1;
                end
            end

            MEASURE: begin
                if (pulse_fall) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    running_d = 1'b0;
                    rv_d      = 1'b1;
                    to_d      = 1'b0;
                    delay_d   = dly_lat_q;
                    width_d   = cnt_q;
                end else if (cnt_q == TIMEOUT) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    running_d = 1'b0;
                    rv_d      = 1'b1;
                    to_d      = 1'b1;
                    delay_d   = dly_lat_q;
                    width_d   = TIMEOUT;
                end else begin
                    cnt_d     = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                running_d = 1'b0;
            end
        endcase
    end

    assign running      = running_q;
    assign result_valid = rv_q;
    assign timeout      = to_q;
    assign delay_out    = delay_q;
    assign width_out    = width_q;

endmodule
